// File: rtl/imem_loader.sv
// imem_loader: byte-serial instruction-memory loader.
// Collects 8-byte frames (ADDR_HI, ADDR_LO, data bytes MSB first, XOR checksum)
// from an asynchronous pad strobe and issues one imem write per verified frame.
module imem_loader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH = 40,
  parameter int BYTE_WIDTH  = 8
) (
  input  logic                   clk_int,
  input  logic                   reset,
  input  logic                   load_mode,
  input  logic                   byte_strobe,
  input  logic [BYTE_WIDTH-1:0]  byte_in,
  output logic                   imem_write,
  output logic [ADDR_WIDTH-1:0]  imem_write_adr,
  output logic [INSTR_WIDTH-1:0] imem_in,
  output logic                   core_hold,
  output logic                   load_busy,
  output logic                   load_error,
  output logic [ADDR_WIDTH-1:0]  frame_count
);

  localparam int DATA_BYTES = INSTR_WIDTH / BYTE_WIDTH;
  localparam int CNT_W      = $clog2(DATA_BYTES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_BYTES - 1);
  localparam logic [CNT_W-1:0]      CNT_DEC  = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] FC_INC   = ADDR_WIDTH'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR_HI = 3'd1;
  localparam logic [2:0] S_ADDR_LO = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;

  logic                   lm_s1, lm_s2, lm_s3;
  logic                   st_s1, st_s2, st_s3;
  logic                   take_p1;
  logic [BYTE_WIDTH-1:0]  cap_p1;
  logic [2:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [BYTE_WIDTH-1:0]  xsum;
  logic [ADDR_WIDTH-1:0]  addr_sh;
  logic [INSTR_WIDTH-1:0] data_sh;
  logic                   lm_rise, lm_fall, strobe_rise;

  assign lm_rise     = lm_s2 & ~lm_s3;
  assign lm_fall     = ~lm_s2 & lm_s3;
  assign strobe_rise = st_s2 & ~st_s3;

  // Two-flop synchronisers plus a third flop for edge detection on both pads
  always_ff @(posedge clk_int or posedge reset) begin
    if (reset) begin
      lm_s1 <= 1'b0;
      lm_s2 <= 1'b0;
      lm_s3 <= 1'b0;
      st_s1 <= 1'b0;
      st_s2 <= 1'b0;
      st_s3 <= 1'b0;
    end else begin
      lm_s1 <= load_mode;
      lm_s2 <= lm_s1;
      lm_s3 <= lm_s2;
      st_s1 <= byte_strobe;
      st_s2 <= st_s1;
      st_s3 <= st_s2;
    end
  end

  // Capture stage: one-cycle take pulse with the byte latched alongside it
  always_ff @(posedge clk_int or posedge reset) begin
    if (reset) begin
      take_p1 <= 1'b0;
      cap_p1  <= '0;
    end else begin
      take_p1 <= strobe_rise;
      if (strobe_rise) cap_p1 <= byte_in;
    end
  end

  // Frame sequencer: assembles shadow address/data, checks XOR, issues the write
  always_ff @(posedge clk_int or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      xsum           <= '0;
      addr_sh        <= '0;
      data_sh        <= '0;
      imem_write     <= 1'b0;
      imem_write_adr <= '0;
      imem_in        <= '0;
      load_error     <= 1'b0;
      frame_count    <= '0;
    end else begin
      imem_write <= 1'b0;
      if (lm_fall) begin
        // Abort wins over a simultaneous take; a partial frame is an error
        if (load_busy) load_error <= 1'b1;
        state <= S_IDLE;
      end else if (state == S_IDLE) begin
        if (lm_rise) begin
          state       <= S_ADDR_HI;
          load_error  <= 1'b0;
          frame_count <= '0;
        end
      end else if (take_p1) begin
        case (state)
          S_ADDR_HI: begin
            addr_sh[ADDR_WIDTH-1:BYTE_WIDTH] <= cap_p1[ADDR_WIDTH-BYTE_WIDTH-1:0];
            xsum  <= cap_p1;
            state <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            addr_sh[BYTE_WIDTH-1:0] <= cap_p1;
            xsum  <= xsum ^ cap_p1;
            cnt   <= CNT_LAST;
            state <= S_DATA;
          end
          S_DATA: begin
            data_sh <= {data_sh[INSTR_WIDTH-BYTE_WIDTH-1:0], cap_p1};
            xsum    <= xsum ^ cap_p1;
            if (cnt == '0) state <= S_CHECK;
            else           cnt   <= cnt - CNT_DEC;
          end
          S_CHECK: begin
            if (cap_p1 == xsum) begin
              imem_write     <= 1'b1;
              imem_write_adr <= addr_sh;
              imem_in        <= data_sh;
              frame_count    <= frame_count + FC_INC;
            end else begin
              load_error <= 1'b1;
            end
            state <= S_ADDR_HI;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Status decode from the registered state and synced session level
  always_comb begin
    load_busy = (state == S_ADDR_LO) || (state == S_DATA) || (state == S_CHECK);
    core_hold = lm_s2 || (state != S_IDLE);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: framed byte loads, checksum errors,
// aborts, back-to-back frames, mid-frame reset and frame_count wrap.
module tb_imem_loader;

  logic        clk_int = 1'b0;
  logic        reset = 1'b1;
  logic        load_mode = 1'b0;
  logic        byte_strobe = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        imem_write;
  logic [9:0]  imem_write_adr;
  logic [39:0] imem_in;
  logic        core_hold;
  logic        load_busy;
  logic        load_error;
  logic [9:0]  frame_count;

  int checks = 0;
  int failures = 0;

  int          wr_count = 0;
  int          long_pulse = 0;
  logic        prev_wr = 1'b0;
  logic [9:0]  last_adr = '0;
  logic [39:0] last_data = '0;

  imem_loader dut (
    .clk_int        (clk_int),
    .reset          (reset),
    .load_mode      (load_mode),
    .byte_strobe    (byte_strobe),
    .byte_in        (byte_in),
    .imem_write     (imem_write),
    .imem_write_adr (imem_write_adr),
    .imem_in        (imem_in),
    .core_hold      (core_hold),
    .load_busy      (load_busy),
    .load_error     (load_error),
    .frame_count    (frame_count)
  );

  always #5 clk_int = ~clk_int;

  // Write monitor: counts pulses, records the written word, flags multi-cycle pulses
  always @(negedge clk_int) begin
    if (imem_write === 1'b1) begin
      wr_count  = wr_count + 1;
      last_adr  = imem_write_adr;
      last_data = imem_in;
      if (prev_wr) long_pulse = long_pulse + 1;
    end
    prev_wr = (imem_write === 1'b1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    #1;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_int);
  endtask

  // One byte at the minimum strobe period: 1 cycle setup, 4 high, 4 low
  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    @(negedge clk_int);
    byte_strobe = 1'b1;
    repeat (4) @(negedge clk_int);
    byte_strobe = 1'b0;
    repeat (3) @(negedge clk_int);
  endtask

  task automatic send_seq(input logic [63:0] v);
    for (int k = 0; k < 8; k++) send_byte(v[63-8*k -: 8]);
  endtask

  task automatic send_frame(input logic [15:0] a16, input logic [39:0] d);
    logic [63:0] v;
    logic [7:0]  chk;
    v = {a16, d, 8'h00};
    chk = 8'h00;
    for (int k = 0; k < 7; k++) chk = chk ^ v[63-8*k -: 8];
    v[7:0] = chk;
    send_seq(v);
  endtask

  initial begin
    int base;

    // Reset state
    idle(3);
    check("rst_write", 64'(imem_write), 64'h0);
    check("rst_adr", 64'(imem_write_adr), 64'h0);
    check("rst_data", 64'(imem_in), 64'h0);
    check("rst_hold", 64'(core_hold), 64'h0);
    check("rst_busy", 64'(load_busy), 64'h0);
    check("rst_err", 64'(load_error), 64'h0);
    check("rst_count", 64'(frame_count), 64'h0);
    reset = 1'b0;
    idle(2);

    // Session start
    load_mode = 1'b1;
    idle(5);
    check("start_hold", 64'(core_hold), 64'h1);
    check("start_busy", 64'(load_busy), 64'h0);

    // Good frame
    send_seq(64'h03FF_1234_5678_9A6E);
    check("good_wrcnt", 64'(wr_count), 64'd1);
    check("good_adr", 64'(imem_write_adr), 64'h3FF);
    check("good_data", 64'(imem_in), 64'h12_3456_789A);
    check("good_count", 64'(frame_count), 64'd1);
    check("good_err", 64'(load_error), 64'h0);
    check("good_busy", 64'(load_busy), 64'h0);

    // Bad checksum
    send_seq(64'h03FF_1234_5678_9A6F);
    check("bad_wrcnt", 64'(wr_count), 64'd1);
    check("bad_err", 64'(load_error), 64'h1);
    check("bad_adr", 64'(imem_write_adr), 64'h3FF);
    check("bad_data", 64'(imem_in), 64'h12_3456_789A);
    check("bad_count", 64'(frame_count), 64'd1);

    // Good frame after an error; error stays sticky
    send_seq(64'h0005_0000_0000_0104);
    check("next_wrcnt", 64'(wr_count), 64'd2);
    check("next_adr", 64'(imem_write_adr), 64'h005);
    check("next_data", 64'(imem_in), 64'h00_0000_0001);
    check("next_err", 64'(load_error), 64'h1);
    check("next_count", 64'(frame_count), 64'd2);

    // Abort a partial frame
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    check("abort_busy_mid", 64'(load_busy), 64'h1);
    load_mode = 1'b0;
    idle(5);
    check("abort_wrcnt", 64'(wr_count), 64'd2);
    check("abort_err", 64'(load_error), 64'h1);
    check("abort_hold", 64'(core_hold), 64'h0);
    check("abort_busy", 64'(load_busy), 64'h0);
    send_byte(8'h5A);
    check("idle_take_busy", 64'(load_busy), 64'h0);
    check("idle_take_wrcnt", 64'(wr_count), 64'd2);

    // Re-raise clears error and count
    load_mode = 1'b1;
    idle(5);
    check("reraise_err", 64'(load_error), 64'h0);
    check("reraise_count", 64'(frame_count), 64'h0);
    check("reraise_hold", 64'(core_hold), 64'h1);

    // Back-to-back frames at minimum strobe period
    base = wr_count;
    send_frame(16'h0001, 40'h01_0203_0405);
    check("b2b0_adr", 64'(imem_write_adr), 64'h001);
    check("b2b0_data", 64'(imem_in), 64'h01_0203_0405);
    send_frame(16'h02AA, 40'hFF_FFFF_FFFF);
    check("b2b1_adr", 64'(imem_write_adr), 64'h2AA);
    check("b2b1_data", 64'(imem_in), 64'hFF_FFFF_FFFF);
    send_frame(16'hA955, 40'h80_0000_0001);
    check("b2b2_adr", 64'(imem_write_adr), 64'h155);
    check("b2b2_data", 64'(imem_in), 64'h80_0000_0001);
    send_frame(16'hFFFF, 40'h00_0000_0000);
    check("b2b3_adr", 64'(imem_write_adr), 64'h3FF);
    check("b2b3_data", 64'(imem_in), 64'h00_0000_0000);
    check("b2b_wrcnt", 64'(wr_count - base), 64'd4);
    check("b2b_count", 64'(frame_count), 64'd4);
    check("b2b_pulse", 64'(long_pulse), 64'd0);

    // Reset in the middle of a frame
    base = wr_count;
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    reset = 1'b1;
    check("mrst_write", 64'(imem_write), 64'h0);
    check("mrst_adr", 64'(imem_write_adr), 64'h0);
    check("mrst_data", 64'(imem_in), 64'h0);
    check("mrst_hold", 64'(core_hold), 64'h0);
    check("mrst_busy", 64'(load_busy), 64'h0);
    check("mrst_err", 64'(load_error), 64'h0);
    check("mrst_count", 64'(frame_count), 64'h0);
    idle(3);
    reset = 1'b0;
    idle(6);
    check("mrst_nowrite", 64'(wr_count - base), 64'd0);
    send_frame(16'h0123, 40'hCA_FEBA_BE00);
    check("mrst_after_adr", 64'(imem_write_adr), 64'h123);
    check("mrst_after_data", 64'(imem_in), 64'hCA_FEBA_BE00);
    check("mrst_after_count", 64'(frame_count), 64'd1);

    // frame_count wrap over 1024 frames, every address written as sent
    load_mode = 1'b0;
    idle(5);
    load_mode = 1'b1;
    idle(5);
    check("wrap_start_count", 64'(frame_count), 64'd0);
    base = wr_count;
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] a;
      a = 10'(i);
      send_frame({6'b0, a}, {a, a, a, a});
      check("wrap_adr", 64'(last_adr), 64'(a));
      check("wrap_data", 64'(last_data), 64'({a, a, a, a}));
    end
    check("wrap_wrcnt", 64'(wr_count - base), 64'd1024);
    check("wrap_count", 64'(frame_count), 64'd0);
    check("wrap_err", 64'(load_error), 64'h0);
    check("final_pulse", 64'(long_pulse), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader that sequences imem initialisation from the pad ring. It collects framed bytes from the 8-bit input port under a slow asynchronous byte strobe, assembles a 10-bit address and a 40-bit instruction, verifies an XOR checksum, and issues one single-cycle write into the core's instruction memory. It replaces the free-running shift register: it adds strobe synchronisation, frame sequencing, integrity checking and a core hold. It sits between the pad block and the digital core.

## Interface
- ADDR_WIDTH, 10, imem address width (address frame carries 2 bytes; only the low ADDR_WIDTH bits are used)
- INSTR_WIDTH, 40, imem word width (must be a multiple of 8)
- BYTE_WIDTH, 8, input port width
- clk_int  input  1  core clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- load_mode  input  1  asynchronous pad level; 1 = loader session active
- byte_strobe  input  1  asynchronous pad strobe; each rising edge delivers one byte
- byte_in  input  BYTE_WIDTH  data from the input port; stable from ≥1 cycle before to ≥3 cycles after the strobe rise
- imem_write  output  1  single-cycle write enable to imem
- imem_write_adr  output  ADDR_WIDTH  write address; held between writes
- imem_in  output  INSTR_WIDTH  write data; held between writes
- core_hold  output  1  holds the core in reset while a session is active
- load_busy  output  1  a frame is partially received
- load_error  output  1  sticky checksum/abort error
- frame_count  output  ADDR_WIDTH  count of successful writes in this session; wraps

## Operation
- load_mode and byte_strobe each pass through a 2-flop synchroniser. A strobe rise edge (sync2 & ~sync3) produces a 1-cycle `take` pulse. byte_in is registered into the capture register on the same cycle as `take`.
- Frame format: 8 bytes, 2 + INSTR_WIDTH/8 + 1.
  - ADDR_HI: bits [1:0] are address [9:8]; bits [7:2] are ignored.
  - ADDR_LO: address [7:0].
  - D0..D4: instruction bytes, MSB first.
  - CHK: XOR of the 7 preceding bytes.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA (5-byte down-counter), CHECK.
  - IDLE → ADDR_HI on rising edge of synced load_mode. That edge also clears load_error and frame_count.
  - Each `take` advances ADDR_HI → ADDR_LO → DATA ×5 → CHECK.
  - On `take` in CHECK: if the received byte equals the running XOR, a registered write is issued and frame_count increments. Otherwise load_error is set and no write occurs. Both cases go back to ADDR_HI.
  - Synced load_mode falling edge in any state → IDLE. A partial frame is discarded with no write; if load_busy was 1, load_error is set.
- Address and data assemble in shadow registers. imem_write_adr and imem_in update only on the cycle imem_write is asserted, so a rejected frame never disturbs them.
- load_busy = state ∈ {ADDR_LO, DATA, CHECK}.
- core_hold = synced load_mode OR (state ≠ IDLE).
- The running XOR restarts at ADDR_HI.

## Timing
- Reset values: imem_write 0, imem_write_adr 0, imem_in 0, core_hold 0, load_busy 0, load_error 0, frame_count 0. FSM resets to IDLE, synchronisers to 0.
- Strobe rise → `take`: 3 clk_int cycles. Checksum `take` → imem_write high: 1 cycle, for exactly 1 cycle.
- Minimum strobe period is 8 cycles: high ≥4 cycles, low ≥4 cycles. Faster strobes are outside the protocol; behaviour is undefined but must never produce a write with a bad checksum.
- A `take` arriving on the same cycle as the load_mode falling edge is dropped; the abort wins.
- A `take` while in IDLE is ignored.
- frame_count wraps from 2^ADDR_WIDTH−1 to 0.
- Reset asserted mid-frame returns to IDLE immediately, with no write pulse.

## Test plan
- Good frame: load_mode=1, then bytes 03,FF,12,34,56,78,9A,6E → one imem_write pulse with adr 0x3FF, data 0x123456789A; frame_count=1, load_error=0.
- Bad checksum: same frame with CHK=6F → no imem_write; load_error=1; adr/data keep their prior values. A following good frame 00,05,00,00,00,00,01,04 → write adr 0x005, data 0x0000000001; load_error stays 1.
- Abort: send 3 bytes, then drop load_mode → no write, load_error=1, core_hold=0 after sync latency. Re-raising load_mode clears load_error and frame_count.
- Back-to-back: 4 good frames at minimum strobe period → exactly 4 writes with correct adr/data; frame_count=4; imem_write pulses are 1 cycle each.
- Reset mid-frame: assert reset after the 5th byte → all outputs return to reset values at once; no write. After release, a full good frame is accepted normally.
- Wrap: preload by issuing 1024 good frames → frame_count returns to 0 and addresses are written exactly as sent.
